// File: rtl/rd_arbiter_if.sv
// Purpose: bundles the requester and read-sequencer handshake signals for rd_arbiter.
// Latency: none; wires only.
// Backpressure: none; clients hold req levels, the sequencer answers go with a ds strobe.
interface rd_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] done;
   logic [NREQ-1:0] err;
   logic            go;
   logic            ds;
   logic            busy;

   // Arbiter side.
   modport master (
      input  req,
      input  ds,
      output gnt,
      output done,
      output err,
      output go,
      output busy
   );

   // Client and sequencer side.
   modport slave (
      output req,
      output ds,
      input  gnt,
      input  done,
      input  err,
      input  go,
      input  busy
   );
endinterface

// File: rtl/rd_arbiter.sv
// Purpose: round-robin (or fixed-priority with RDARB_FIXED_PRIO_EN) arbiter sharing one read sequencer.
// Latency: req sampled in IDLE -> gnt/go/busy one cycle later; done/err one cycle after ds or timeout.
// Backpressure: grant held until sequencer ds or watchdog expiry; new requests wait in IDLE only.
module rd_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   rd_arbiter_if.master bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ok_q, ok_d;     // 1 = completed by ds, 0 = watchdog abort

   logic            found;
   logic [PW-1:0]   win_idx;

`ifdef RDARB_FIXED_PRIO_EN
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            found   = 1'b1;
            win_idx = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] gnt_enc;

   // Round-robin search starting one past the last winner, wrapping.
   always_comb begin
      logic [PW-1:0] cand;
      cand    = '0;
      found   = 1'b0;
      win_idx = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = PW'((int'(ptr_q) + i) % NREQ);
         if (!found && bus.req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Encode the held one-hot grant so RELEASE can move the pointer to it.
   always_comb begin
      gnt_enc = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) gnt_enc = PW'(i);
      end
   end

   // Pointer follows the requester just served; reset makes req[0] win first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= PW'(NREQ - 1);
      end else if (state_q == RELEASE) begin
         ptr_q <= gnt_enc;
      end
   end
`endif

   // State, grant, watchdog and completion-flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, strobe in ISSUE, watch in WAIT, report in RELEASE.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      ok_d    = ok_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Saturating count; ds takes precedence over a same-cycle timeout.
            if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
            if (bus.ds) begin
               ok_d    = 1'b1;
               state_d = RELEASE;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               ok_d    = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode registered state only; gnt_q stays loaded in RELEASE to steer done/err.
   assign bus.go   = (state_q == ISSUE);
   assign bus.busy = (state_q != IDLE);
   assign bus.gnt  = ((state_q == ISSUE) || (state_q == WAIT)) ? gnt_q : '0;
   assign bus.done = ((state_q == RELEASE) &&  ok_q) ? gnt_q : '0;
   assign bus.err  = ((state_q == RELEASE) && !ok_q) ? gnt_q : '0;

endmodule

// File: tb/tb_rd_arbiter.sv
// Purpose: self-checking bench for rd_arbiter with a scoreboard monitor and a simple sequencer model.
// Latency: expects gnt/go one cycle after req, done/err one cycle after ds or TIMEOUT+1 WAIT cycles.
// Backpressure: sequencer model answers go with ds after a programmable number of WAIT cycles.
module tb_rd_arbiter;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;
   int   n_go;
   int   n_end;
   int   go_cyc;
   int   end_cyc;
   int   blen;
   int   ds_delay;    // 0 = sequencer never answers

   logic [3:0] exp_gnt_q[$];
   logic [7:0] exp_end_q[$];   // {done, err}
   int         exp_len_q[$];

   rd_arbiter_if #(.NREQ(NREQ)) bus ();

   rd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops scoreboard entries whenever the DUT presents go, done/err or ends a busy run.
   initial begin
      logic [7:0] e;
      n_go = 0; n_end = 0; go_cyc = 0; end_cyc = 0; blen = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            blen = 0;
         end else begin
            if (bus.gnt != '0) chk("gnt_onehot", $countones(bus.gnt), 1);
            if (bus.go) begin
               n_go++;
               go_cyc = cyc;
               if (exp_gnt_q.size() == 0) chk("unexpected_go", {28'h0, bus.gnt}, 32'h0);
               else chk("gnt_at_go", {28'h0, bus.gnt}, {28'h0, exp_gnt_q.pop_front()});
            end
            if ((bus.done | bus.err) != '0) begin
               n_end++;
               end_cyc = cyc;
               if (exp_end_q.size() == 0) chk("unexpected_end", {24'h0, bus.done, bus.err}, 32'h0);
               else begin
                  e = exp_end_q.pop_front();
                  chk("done_vec", {28'h0, bus.done}, {28'h0, e[7:4]});
                  chk("err_vec", {28'h0, bus.err}, {28'h0, e[3:0]});
               end
            end
            if (bus.busy) begin
               blen++;
            end else if (blen != 0) begin
               if (exp_len_q.size() == 0) chk("unexpected_busy_run", blen, 0);
               else chk("busy_len", blen, exp_len_q.pop_front());
               blen = 0;
            end
         end
      end
   end

   // Read-sequencer model: ds during the ds_delay-th WAIT cycle after go.
   initial begin
      bus.ds = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && bus.go && ds_delay != 0) begin
            repeat (ds_delay) @(posedge clk);
            #1 bus.ds = 1'b1;
            @(posedge clk);
            #1 bus.ds = 1'b0;
         end
      end
   end

   task automatic wait_go(input int target, input int budget);
      int k;
      k = 0;
      while (n_go < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (n_go < target) chk("wait_go_timeout", n_go, target);
   endtask

   task automatic wait_end(input int target, input int budget);
      int k;
      k = 0;
      while (n_end < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (n_end < target) chk("wait_end_timeout", n_end, target);
   endtask

   // One transaction; called one tick after a rising edge with the DUT idle.
   task automatic run_one(input logic [3:0] r, input logic [3:0] g, input int dly,
                          input bit abort, input int len);
      int go0, end0;
      go0 = n_go; end0 = n_end;
      ds_delay = dly;
      exp_gnt_q.push_back(g);
      exp_end_q.push_back(abort ? {4'h0, g} : {g, 4'h0});
      exp_len_q.push_back(len);
      bus.req = r;
      wait_go(go0 + 1, 20);
      #1 bus.req = '0;
      wait_end(end0 + 1, 40);
      #1;
   endtask

   initial begin
      int go0, end0;
      logic [3:0] fair_req;
      logic [3:0] fair_gnt[4];
      int         fair_n;
      checks = 0; errors = 0; ds_delay = 3;
      rst = 1'b1;
      bus.req = '0;

      // Reset values.
      #11;
      chk("rst_gnt", {28'h0, bus.gnt}, 32'h0);
      chk("rst_done", {28'h0, bus.done}, 32'h0);
      chk("rst_err", {28'h0, bus.err}, 32'h0);
      chk("rst_go", {31'h0, bus.go}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Fairness with a constant request pattern, back-to-back transactions.
`ifdef RDARB_FIXED_PRIO_EN
      fair_req = 4'b0110; fair_n = 3;
      fair_gnt[0] = 4'b0010; fair_gnt[1] = 4'b0010; fair_gnt[2] = 4'b0010; fair_gnt[3] = 4'b0010;
`else
      fair_req = 4'b1011; fair_n = 4;
      fair_gnt[0] = 4'b0001; fair_gnt[1] = 4'b0010; fair_gnt[2] = 4'b1000; fair_gnt[3] = 4'b0001;
`endif
      go0 = n_go; end0 = n_end;
      ds_delay = 3;
      for (int k = 0; k < fair_n; k++) begin
         exp_gnt_q.push_back(fair_gnt[k]);
         exp_end_q.push_back({fair_gnt[k], 4'h0});
         exp_len_q.push_back(5);
      end
      bus.req = fair_req;
      for (int k = 1; k <= fair_n; k++) begin
         wait_go(go0 + k, 40);
         #1;
         if (k > 1) chk("b2b_gap", go_cyc - end_cyc, 2);
         if (k == fair_n) bus.req = '0;
      end
      wait_end(end0 + fair_n, 100);
      #1;

      // Single request with explicit go/gnt timing.
      go0 = n_go; end0 = n_end;
      ds_delay = 3;
      exp_gnt_q.push_back(4'b0100);
      exp_end_q.push_back({4'b0100, 4'h0});
      exp_len_q.push_back(5);
      bus.req = 4'b0100;
      @(posedge clk); #1;
      chk("single_go", {31'h0, bus.go}, 32'h1);
      chk("single_busy", {31'h0, bus.busy}, 32'h1);
      chk("single_gnt", {28'h0, bus.gnt}, 32'h4);
      bus.req = '0;
      @(posedge clk); #1;
      chk("single_go_one_cycle", {31'h0, bus.go}, 32'h0);
      chk("single_gnt_held", {28'h0, bus.gnt}, 32'h4);
      wait_end(end0 + 1, 40);
      #1;

      // Watchdog abort, then a normal transaction afterwards.
      run_one(4'b0010, 4'b0010, 0, 1'b1, TIMEOUT + 3);
      run_one(4'b1000, 4'b1000, 3, 1'b0, 5);

      // ds on the very cycle the watchdog would expire: completion wins.
      run_one(4'b0001, 4'b0001, TIMEOUT + 1, 1'b0, TIMEOUT + 3);

      // Reset in the middle of WAIT: everything drops, no pulse, pointer restarts.
      go0 = n_go;
      ds_delay = 0;
      exp_gnt_q.push_back(4'b0100);
      bus.req = 4'b0100;
      wait_go(go0 + 1, 20);
      #1 bus.req = '0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_gnt", {28'h0, bus.gnt}, 32'h0);
      chk("midrst_go", {31'h0, bus.go}, 32'h0);
      chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
      chk("midrst_done", {28'h0, bus.done}, 32'h0);
      chk("midrst_err", {28'h0, bus.err}, 32'h0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      run_one(4'b0011, 4'b0001, 3, 1'b0, 5);

      repeat (4) @(posedge clk);
      #1;
      chk("left_gnt_exp", exp_gnt_q.size(), 0);
      chk("left_end_exp", exp_end_q.size(), 0);
      chk("left_len_exp", exp_len_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
